// File: rtl/led_pattern_arb_if.sv
// Request/grant bundle between the LED requesters and the pattern arbiter.
// The requester side drives REQ/REQ_PAT; the arbiter drives the grant status and the LED.
interface led_pattern_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   REQ;
  logic [3*NREQ-1:0] REQ_PAT;
  logic              LED_OUT;
  logic              ACTIVE_VLD;
  logic [2:0]        ACTIVE_ID;
  logic [NREQ-1:0]   ACK;

  modport master (
    output REQ, REQ_PAT,
    input  LED_OUT, ACTIVE_VLD, ACTIVE_ID, ACK
  );

  modport slave (
    input  REQ, REQ_PAT,
    output LED_OUT, ACTIVE_VLD, ACTIVE_ID, ACK
  );
endinterface

// File: rtl/led_pattern_arb.sv
// Fixed-priority arbiter for the status LED: grants the lowest-index requester,
// holds each grant for HOLD_TICKS 1 Hz ticks, and muxes the latched blink pattern to LED_OUT.
module led_pattern_arb #(
  parameter int NREQ       = 4,
  parameter int HOLD_TICKS = 2
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic CLK_1HZ,
  input  logic CLK_2HZ,
  input  logic CLK_4HZ,
  input  logic CLK_4HZ_500MS,
  input  logic CLK_4HZ_3500MS,
  input  logic CLK_07S,
  led_pattern_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

  state_t          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      pat_q, pat_d;
  logic [3:0]      hold_q, hold_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            clk1_q, clk1_d;
  logic            led_q, led_d;

  logic            tick;
  logic            any_req;
  logic            higher_req;
  logic            owner_req;
  logic [2:0]      winner;
  logic [2:0]      win_pat;
  logic            do_grant;

  function automatic logic pat_wave(
    input logic [2:0] pat,
    input logic       w1hz,
    input logic       w2hz,
    input logic       w4hz,
    input logic       w4hz_500,
    input logic       w4hz_3500,
    input logic       w07s
  );
    logic r;
    case (pat)
      3'd0:    r = 1'b0;
      3'd1:    r = 1'b1;
      3'd2:    r = w1hz;
      3'd3:    r = w2hz;
      3'd4:    r = w4hz;
      3'd5:    r = w4hz_500;
      3'd6:    r = w4hz_3500;
      default: r = w07s;
    endcase
    return r;
  endfunction

  assign tick    = CLK_1HZ & ~clk1_q;
  assign any_req = |bus.REQ;
  assign clk1_d  = CLK_1HZ;

  // Request decode: winner, its pattern, and whether anyone outranks the owner
  always_comb begin
    winner     = 3'd0;
    win_pat    = 3'd0;
    higher_req = 1'b0;
    owner_req  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.REQ[i]) winner = 3'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == winner) win_pat = bus.REQ_PAT[3*i +: 3];
      if (bus.REQ[i] && (3'(i) < owner_q)) higher_req = 1'b1;
      if (3'(i) == owner_q) owner_req = bus.REQ[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pat_d    = pat_q;
    hold_d   = hold_q;
    ack_d    = '0;
    do_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) do_grant = 1'b1;
      end
      S_HOLD: begin
        // Preemption beats a coincident tick; the owner's own REQ is ignored while holding
        if (higher_req) begin
          do_grant = 1'b1;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_RUN;
          end else if (hold_q != 4'hf) begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      S_RUN: begin
        if (higher_req) begin
          do_grant = 1'b1;
        end else if (!owner_req) begin
          if (any_req) begin
            do_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
            owner_d = 3'd0;
            pat_d   = 3'd0;
            hold_d  = 4'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = 3'd0;
        pat_d   = 3'd0;
        hold_d  = 4'd0;
      end
    endcase

    if (do_grant) begin
      state_d = S_HOLD;
      owner_d = winner;
      pat_d   = win_pat;
      hold_d  = 4'd0;
      for (int i = 0; i < NREQ; i++) begin
        ack_d[i] = (3'(i) == winner);
      end
    end
  end

  // LED samples the pattern latched on the previous edge, so it trails a grant by one cycle
  always_comb begin
    led_d = pat_wave(pat_q, CLK_1HZ, CLK_2HZ, CLK_4HZ,
                     CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S);
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      owner_q <= 3'd0;
      pat_q   <= 3'd0;
      hold_q  <= 4'd0;
      ack_q   <= '0;
      clk1_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pat_q   <= pat_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      clk1_q  <= clk1_d;
      led_q   <= led_d;
    end
  end

  assign bus.LED_OUT    = led_q;
  assign bus.ACTIVE_VLD = (state_q != S_IDLE);
  assign bus.ACTIVE_ID  = owner_q;
  assign bus.ACK        = ack_q;

endmodule

// File: tb/tb_led_pattern_arb.sv
// Scoreboard bench for led_pattern_arb: a tick-counting reference model queues the
// expected outputs each edge and a negedge monitor pops and compares them.
module tb_led_pattern_arb;
  localparam int NREQ = 4;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_1hz = 1'b0, clk_2hz = 1'b0, clk_4hz = 1'b0;
  logic clk_4hz_500 = 1'b0, clk_4hz_3500 = 1'b0, clk_07s = 1'b0;

  led_pattern_arb_if #(.NREQ(NREQ)) bus ();

  led_pattern_arb #(.NREQ(NREQ), .HOLD_TICKS(HOLD)) dut (
    .SYSCLK         (clk),
    .RESET_N        (rst_n),
    .CLK_1HZ        (clk_1hz),
    .CLK_2HZ        (clk_2hz),
    .CLK_4HZ        (clk_4hz),
    .CLK_4HZ_500MS  (clk_4hz_500),
    .CLK_4HZ_3500MS (clk_4hz_3500),
    .CLK_07S        (clk_07s),
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            vld;
    logic [2:0]      id;
    logic [NREQ-1:0] ack;
    logic            led;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic wave(input int p);
    case (p)
      0: return 1'b0;
      1: return 1'b1;
      2: return clk_1hz;
      3: return clk_2hz;
      4: return clk_4hz;
      5: return clk_4hz_500;
      6: return clk_4hz_3500;
      default: return clk_07s;
    endcase
  endfunction

  // Waveform generator: 1 Hz has a 100-cycle period
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      clk_1hz      = (cyc % 100) < 50;
      clk_2hz      = (cyc % 50) < 25;
      clk_4hz      = (cyc % 24) < 12;
      clk_4hz_500  = ((cyc % 200) < 50) && ((cyc % 24) < 12);
      clk_4hz_3500 = ((cyc % 200) >= 50) && ((cyc % 24) < 12);
      clk_07s      = (cyc % 140) < 70;
    end
  end

  // Reference model: owner (-1 = none), ticks seen since grant, latched pattern
  initial begin
    int   owner = -1;
    int   ticks = 0;
    int   pat = 0;
    bit   prev1 = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        owner = -1; ticks = 0; pat = 0; prev1 = 1'b0;
      end else begin
        bit tick;
        bit any;
        bit higher;
        bit grant;
        int w;
        tick = clk_1hz && !prev1;
        any = (bus.REQ != '0);
        w = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (bus.REQ[i]) w = i;
        e.ack = '0;
        e.led = wave(pat);
        grant = 1'b0;
        if (owner < 0) begin
          grant = any;
        end else begin
          higher = 1'b0;
          for (int i = 0; i < owner; i++) if (bus.REQ[i]) higher = 1'b1;
          if (higher) grant = 1'b1;
          else if (ticks < HOLD) begin
            if (tick) ticks++;
          end else if (!bus.REQ[owner]) begin
            if (any) grant = 1'b1;
            else begin owner = -1; pat = 0; end
          end
        end
        if (grant) begin
          owner = w;
          pat = int'(bus.REQ_PAT[3*w +: 3]);
          ticks = 0;
          e.ack[w] = 1'b1;
        end
        prev1 = clk_1hz;
        e.vld = (owner >= 0);
        e.id = (owner >= 0) ? 3'(owner) : 3'd0;
        q.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        chk("rst_vld", int'(bus.ACTIVE_VLD), 0);
        chk("rst_led", int'(bus.LED_OUT), 0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("active_vld", int'(bus.ACTIVE_VLD), int'(e.vld));
        chk("active_id", int'(bus.ACTIVE_ID), int'(e.id));
        chk("ack", int'(bus.ACK), int'(e.ack));
        chk("led_out", int'(bus.LED_OUT), int'(e.led));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [NREQ-1:0] r, input logic [3*NREQ-1:0] p);
    bus.REQ = r;
    bus.REQ_PAT = p;
  endtask

  task automatic wait_1hz(input logic level);
    int n = 0;
    while (clk_1hz !== level && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) chk("wait_1hz_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", int'(bus.ACTIVE_VLD), 0);
    chk("async_rst_id", int'(bus.ACTIVE_ID), 0);
    chk("async_rst_ack", int'(bus.ACK), 0);
    chk("async_rst_led", int'(bus.LED_OUT), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    set_req('0, '0);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    step(3);

    // Basic grant: requester 2, pattern 1, dropped during hold
    set_req(4'b0100, 12'(1 << 6));
    step(2);
    set_req('0, 12'(1 << 6));
    step(300);

    // Preemption: 3 in RUN with pattern 2, then 0 with pattern 4
    set_req(4'b1000, 12'(2 << 9));
    step(300);
    set_req(4'b1001, 12'((2 << 9) | 4));
    step(150);
    set_req(4'b1000, 12'(2 << 9));
    step(300);
    set_req('0, '0);
    step(5);

    // Handover: 1 and 2 request, 1 drops in RUN while 2 changes its pattern
    set_req(4'b0110, 12'((3 << 6) | (5 << 3)));
    step(300);
    set_req(4'b0100, 12'((6 << 6) | (5 << 3)));
    step(300);
    set_req('0, '0);
    step(5);

    // REQ[1] rises exactly on the tick that would finish owner 3's hold
    set_req(4'b1000, 12'(7 << 9));
    step(2);
    wait_1hz(1'b0);
    wait_1hz(1'b1);
    wait_1hz(1'b0);
    wait_1hz(1'b1);
    set_req(4'b1010, 12'((7 << 9) | (4 << 3)));
    step(300);
    set_req('0, '0);
    step(5);

    // Pattern freeze: owner changes its code from 3 to 0 while granted
    set_req(4'b0001, 12'd3);
    step(50);
    set_req(4'b0001, 12'd0);
    step(300);
    set_req('0, '0);
    step(5);

    // Reset mid-hold with the request kept high
    set_req(4'b0010, 12'(1 << 3));
    step(50);
    pulse_reset();
    step(300);
    set_req('0, '0);
    step(5);

    // Randomised traffic
    for (int s = 0; s < 40; s++) begin
      set_req(4'($urandom_range(0, 15)), 12'($urandom));
      step($urandom_range(1, 200));
    end
    set_req('0, '0);
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
